// File: rtl/id_hazard_scoreboard.sv
// id_hazard_scoreboard
// ID-stage interlock controller. Each architectural register r (1..31) owns a
// small down-counter that is loaded when an instruction writing r issues and
// counts down to zero as the result becomes readable. The instruction in ID is
// held (id_stall) while any register it reads or writes is still pending.
//
// Optional feature macro: ID_FORWARDING_EN
//   defined   - EX/MEM forwarding present: ALU writers never mark a register
//               busy, loads mark rd busy for one cycle (single load-use bubble).
//   undefined - full interlock: ALU results busy ALU_LAT cycles, loads LOAD_LAT.
module id_hazard_scoreboard #(
  parameter logic [4:0] OP_NOP   = 5'b00000,
  parameter logic [4:0] OP_LOAD  = 5'b00010,
  parameter logic [4:0] OP_STORE = 5'b00011,
  parameter int         ALU_LAT  = 2,
  parameter int         LOAD_LAT = 3,
  parameter int         CNT_W    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] IF_ID_Instruction,
  input  logic        id_valid,
  input  logic        ex_hold,
  input  logic        id_flush,
  output logic        id_stall,
  output logic        id_issue,
  output logic [31:0] busy_mask,
  output logic [15:0] stall_count
);

  // Value loaded into a destination's busy counter when its writer issues.
`ifdef ID_FORWARDING_EN
  localparam logic [CNT_W-1:0] ALU_SET  = '0;
  localparam logic [CNT_W-1:0] LOAD_SET = CNT_W'(1);
`else
  localparam logic [CNT_W-1:0] ALU_SET  = CNT_W'(ALU_LAT);
  localparam logic [CNT_W-1:0] LOAD_SET = CNT_W'(LOAD_LAT);
`endif

  // Saturating increment for the hazard-cycle counter.
  function automatic logic [15:0] sat_inc(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

  logic [4:0]       opcode;
  logic [4:0]       rb;
  logic [4:0]       rd;
  logic [4:0]       src_a;
  logic [4:0]       src_b;
  logic [4:0]       dst;
  logic [CNT_W-1:0] lat_val;
  logic             hazard;
  logic [CNT_W-1:0] busy_cnt [1:31];
  logic             unused_fields;

  assign opcode = IF_ID_Instruction[31:27];
  assign rb     = IF_ID_Instruction[26:22];
  assign rd     = IF_ID_Instruction[21:17];

  // Immediate and spare bit are irrelevant to hazard detection.
  assign unused_fields = ^IF_ID_Instruction[16:0];

  // Decode which registers the ID instruction reads and writes (0 = none).
  always_comb begin
    src_a   = (opcode == OP_NOP) ? 5'd0 : rb;
    src_b   = (opcode == OP_STORE) ? rd : 5'd0;
    dst     = ((opcode == OP_NOP) || (opcode == OP_STORE)) ? 5'd0 : rd;
    lat_val = (opcode == OP_LOAD) ? LOAD_SET : ALU_SET;
  end

  // Pending-write view of the counters; register 0 is never busy.
  always_comb begin
    busy_mask    = '0;
    for (int r = 1; r < 32; r++) begin
      busy_mask[r] = (busy_cnt[r] != '0);
    end
  end

  // Interlock decisions, all combinational from registered state. Gated by
  // rst_n so both handshakes are quiet while reset is asserted.
  always_comb begin
    hazard   = id_valid & ~id_flush &
               (busy_mask[src_a] | busy_mask[src_b] | busy_mask[dst]);
    id_stall = rst_n & (hazard | (id_valid & ex_hold & ~id_flush));
    id_issue = rst_n & id_valid & ~id_flush & ~hazard & ~ex_hold;
  end

  // Busy counters: a newly issued writer reloads its destination (wins over
  // the decrement); everything else drains toward zero even under ex_hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 1; r < 32; r++) begin
        busy_cnt[r] <= '0;
      end
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (id_issue && (dst == 5'(r))) begin
          busy_cnt[r] <= lat_val;
        end else if (busy_cnt[r] != '0) begin
          busy_cnt[r] <= busy_cnt[r] - CNT_W'(1);
        end
      end
    end
  end

  // Count hazard cycles (not pure back-pressure cycles), saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (hazard) begin
      stall_count <= sat_inc(stall_count);
    end
  end

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Testbench for id_hazard_scoreboard. Reference model tracks, per register,
// the absolute cycle at which its pending result becomes readable, and
// derives every expected output from that each cycle.
module tb_id_hazard_scoreboard;

  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_ALU   = 5'b00001;
  localparam logic [4:0] OP_ALU2  = 5'b10100;
  localparam logic [4:0] OP_LOAD  = 5'b00010;
  localparam logic [4:0] OP_STORE = 5'b00011;
`ifdef ID_FORWARDING_EN
  localparam int ALU_L  = 0;
  localparam int LOAD_L = 1;
`else
  localparam int ALU_L  = 2;
  localparam int LOAD_L = 3;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] IF_ID_Instruction;
  logic        id_valid;
  logic        ex_hold;
  logic        id_flush;
  logic        id_stall;
  logic        id_issue;
  logic [31:0] busy_mask;
  logic [15:0] stall_count;

  id_hazard_scoreboard dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .IF_ID_Instruction (IF_ID_Instruction),
    .id_valid          (id_valid),
    .ex_hold           (ex_hold),
    .id_flush          (id_flush),
    .id_stall          (id_stall),
    .id_issue          (id_issue),
    .busy_mask         (busy_mask),
    .stall_count       (stall_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int ready_at [32];
  int sc_m    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rb,
                                     input logic [4:0] rd, input logic [15:0] imm);
    return {op, rb, rd, 1'b0, imm};
  endfunction

  function automatic logic m_busy(input logic [4:0] r);
    return (r != 5'd0) && (cyc < ready_at[r]);
  endfunction

  // One clock cycle: drive, check against the model, advance the model.
  task automatic step(input logic [31:0] ins, input logic v, input logic h,
                      input logic f, output logic iss);
    logic [4:0]  op, rb, rd, a, b, d;
    logic        hz, is_m, st_m;
    logic [31:0] mask;
    IF_ID_Instruction = ins;
    id_valid = v;
    ex_hold  = h;
    id_flush = f;
    #2;
    op = ins[31:27];
    rb = ins[26:22];
    rd = ins[21:17];
    a  = (op == OP_NOP) ? 5'd0 : rb;
    b  = (op == OP_STORE) ? rd : 5'd0;
    d  = (op == OP_NOP || op == OP_STORE) ? 5'd0 : rd;
    hz   = v && !f && (m_busy(a) || m_busy(b) || m_busy(d));
    is_m = v && !f && !hz && !h;
    st_m = hz || (v && h && !f);
    mask = '0;
    for (int r = 1; r < 32; r++) mask[r] = m_busy(5'(r));
    check("id_stall", {31'd0, id_stall}, {31'd0, st_m});
    check("id_issue", {31'd0, id_issue}, {31'd0, is_m});
    check("busy_mask", busy_mask, mask);
    check("stall_count", {16'd0, stall_count}, 32'(sc_m));
    iss = id_issue;
    @(posedge clk);
    if (is_m && d != 5'd0)
      ready_at[d] = cyc + ((op == OP_LOAD) ? LOAD_L : ALU_L) + 1;
    if (hz && sc_m < 65535) sc_m++;
    cyc++;
    #1;
  endtask

  // Asynchronous reset applied mid-cycle with traffic on the inputs.
  task automatic do_reset();
    IF_ID_Instruction = mk(OP_ALU, 5'd3, 5'd3, 16'h1);
    id_valid = 1'b1;
    ex_hold  = 1'b1;
    id_flush = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_busy_mask", busy_mask, 32'd0);
    check("rst_stall_count", {16'd0, stall_count}, 32'd0);
    check("rst_id_stall", {31'd0, id_stall}, 32'd0);
    check("rst_id_issue", {31'd0, id_issue}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int r = 0; r < 32; r++) ready_at[r] = 0;
    sc_m = 0;
    cyc++;
  endtask

  // Issue 'first', then present 'dep' until it issues; count waiting cycles.
  task automatic run_dep(input string tag, input logic [31:0] first,
                         input logic [31:0] dep, input int hold_cycles,
                         input int exp_wait);
    logic iss;
    int   n;
    logic done;
    step(first, 1'b1, 1'b0, 1'b0, iss);
    check({tag, "_first_issue"}, {31'd0, iss}, 32'd1);
    n = 0;
    done = 1'b0;
    while (!done && n < 12) begin
      step(dep, 1'b1, (n < hold_cycles), 1'b0, iss);
      if (iss) done = 1'b1;
      else n++;
    end
    check({tag, "_wait"}, 32'(n), 32'(exp_wait));
  endtask

  initial begin
    logic iss;
    logic [4:0] op;
    for (int r = 0; r < 32; r++) ready_at[r] = 0;
    rst_n = 1'b0;
    IF_ID_Instruction = '0;
    id_valid = 1'b0;
    ex_hold  = 1'b0;
    id_flush = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(32'd0, 1'b0, 1'b0, 1'b0, iss);

    // ALU read-after-write
    do_reset();
    run_dep("alu_raw", mk(OP_ALU, 5'd1, 5'd5, 16'h0), mk(OP_ALU, 5'd5, 5'd6, 16'h0), 0, ALU_L);
    check("alu_raw_count", {16'd0, stall_count}, 32'(ALU_L));

    // Load-use
    do_reset();
    run_dep("load_use", mk(OP_LOAD, 5'd2, 5'd7, 16'h4), mk(OP_ALU, 5'd7, 5'd8, 16'h0), 0, LOAD_L);
    check("load_use_count", {16'd0, stall_count}, 32'(LOAD_L));

    // Store reads rd as a source
    do_reset();
    run_dep("store_rd", mk(OP_ALU, 5'd1, 5'd9, 16'h0), mk(OP_STORE, 5'd0, 5'd9, 16'h8), 0, ALU_L);

    // Writes to r0 never create a dependency
    do_reset();
    run_dep("r0_write", mk(OP_ALU, 5'd1, 5'd0, 16'h0), mk(OP_ALU, 5'd0, 5'd4, 16'h0), 0, 0);
    check("r0_count", {16'd0, stall_count}, 32'd0);

    // Back-pressure overlapping a hazard: counters keep draining
    do_reset();
    run_dep("overlap", mk(OP_ALU, 5'd1, 5'd5, 16'h0), mk(OP_ALU, 5'd5, 5'd6, 16'h0), 2,
            (ALU_L > 2) ? ALU_L : 2);
    check("overlap_count", {16'd0, stall_count}, 32'(ALU_L));

    // Flush with a pending hazard leaves the scoreboard intact
    do_reset();
    step(mk(OP_LOAD, 5'd1, 5'd7, 16'h0), 1'b1, 1'b0, 1'b0, iss);
    #1;
    check("flush_pre_mask7", {31'd0, busy_mask[7]}, 32'd1);
    step(mk(OP_ALU, 5'd7, 5'd8, 16'h0), 1'b1, 1'b0, 1'b1, iss);
    check("flush_issue", {31'd0, iss}, 32'd0);
    begin
      int n;
      n = 0;
      iss = 1'b0;
      while (!iss && n < 12) begin
        step(mk(OP_ALU, 5'd7, 5'd8, 16'h0), 1'b1, 1'b0, 1'b0, iss);
        if (!iss) n++;
      end
      check("flush_then_wait", 32'(n), 32'(LOAD_L - 1));
    end

    // Randomized traffic with an asynchronous reset in the middle
    for (int k = 0; k < 600; k++) begin
      if (k == 300) do_reset();
      case ($urandom_range(0, 4))
        0: op = OP_NOP;
        1: op = OP_ALU;
        2: op = OP_ALU2;
        3: op = OP_LOAD;
        default: op = OP_STORE;
      endcase
      step(mk(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)),
           ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 2),
           ($urandom_range(0, 19) == 0), iss);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
